issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries (power of 2, >=4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  in  1  discard all queued entries.
REQ-005 SHALL have port stallE  in  1  execute stage not accepting (driven by alustallE or hazard stall).
REQ-006 SHALL have ports push_en1, push_en2  in  1 each  fetch slot 1/2 valid.
REQ-007 SHALL have ports push_pc1, push_pc2, push_instr1, push_instr2  in  32 each  fetched PC/instruction.
REQ-008 SHALL have ports push_dst1, push_dst2  in  5 each  pre-decoded destination GPR (0 = none).
REQ-009 SHALL have ports push_md1, push_md2  in  1 each  mul/div/madd/msub/mthi/mtlo class.
REQ-010 SHALL have ports push_br1, push_br2  in  1 each  branch/jump class.
REQ-011 SHALL have port full  out  1  fewer than 2 free entries.
REQ-012 SHALL have ports master_valid, slave_valid  out  1 each  issue slot valid this cycle.
REQ-013 SHALL have ports master_pc, master_instr, slave_pc, slave_instr  out  32 each  issued entries.
REQ-014 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL store entries in a circular buffer with wr_ptr/rd_ptr wrapping modulo DEPTH.
REQ-016 SHALL accept pushes only when full=0; push_en1 writes at wr_ptr, push_en2 (only with push_en1) at wr_ptr+1; push_en2 without push_en1 SHALL be ignored.
REQ-017 SHALL make a written entry visible at the head no earlier than the cycle after the write (no bypass).
REQ-018 SHALL drive master_valid = (count>=1); master_* = entry at rd_ptr.
REQ-019 SHALL drive slave_valid = (count>=2) & ~conflict; slave_* = entry at rd_ptr+1.
REQ-020 SHALL assert conflict when slave rs (instr[25:21]) or rt (instr[20:16]) equals master dst with master dst != 0.
REQ-021 SHALL assert conflict when master and slave both have md=1 (mul/div unit single-issue).
REQ-022 SHALL assert conflict when slave has br=1 (branch always leads the next pair with its delay slot).
REQ-023 SHALL, when stallE=0, pop master_valid+slave_valid entries; when stallE=1, pop none and hold outputs stable.
REQ-024 SHALL update count = count + pushed - popped on simultaneous push and pop in one cycle.
REQ-025 SHALL, on flush, zero count and both pointers at the next edge, with priority over push and pop in that cycle.
REQ-026 SHALL drive master_pc/instr and slave_pc/instr to 0 when the corresponding valid is 0.

Reset
REQ-027 SHALL, while rst=0, force count=0, wr_ptr=rd_ptr=0, full=0, master_valid=slave_valid=0, all data outputs 0.
REQ-028 SHALL discard any in-progress push/pop when rst asserts mid-cycle; storage array contents need not be cleared.

Configuration
REQ-029 SHALL, with macro DUAL_ISSUE_EN defined, issue per REQ-019..022.
REQ-030 SHALL, without DUAL_ISSUE_EN, tie slave_valid to 0 and pop at most one entry per cycle.

Structure
REQ-031 SHALL place the entry struct typedef (pc, instr, dst, md, br) and ISSUE_QUEUE_DEPTH constant in the shared pipeline package.
REQ-032 SHALL implement the conflict logic (REQ-020..022) in one combinational sub-module dual_issue_check.

Verification
REQ-033 SHALL cover: reset, push pair (addu $3; addu $4) -> next cycle master_valid=slave_valid=1, count 2 -> 0 after one unstalled cycle.
REQ-034 SHALL cover: master addu $5, slave subu $6,$5,$1 -> slave_valid=0, one pop, slave entry becomes master next cycle.
REQ-035 SHALL cover: master mult, slave div -> slave_valid=0; master mult, slave addu -> slave_valid=1.
REQ-036 SHALL cover: 4 pushes of pairs into DEPTH=8 with stallE=1 -> full=1 at count 7 or 8, further push ignored, count unchanged.
REQ-037 SHALL cover: count=6 with push pair and dual pop in same cycle -> count stays 6; pointers wrap past DEPTH-1 correctly.
REQ-038 SHALL cover: flush with simultaneous push pair -> count=0, master_valid=0 next cycle; rst=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared pipeline definitions for the issue queue: entry layout, default depth
// and instruction field helpers used by the dual-issue conflict check.
package issue_queue_pkg;

    localparam int ISSUE_QUEUE_DEPTH = 8;

    // One queued instruction with its pre-decoded issue attributes
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  dst;   // destination GPR, 0 = none
        logic        md;    // mul/div unit class
        logic        br;    // branch/jump class
    } iq_entry_t;

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/issue_queue_dual_issue_check.sv
// Pairing rules for the slave issue slot: RAW on the master's destination,
// a second mul/div op, or a slave branch all force single issue.
module dual_issue_check
    import issue_queue_pkg::*;
(
    input  logic [4:0] master_dst_i,
    input  logic       master_md_i,
    input  logic [4:0] slave_rs_i,
    input  logic [4:0] slave_rt_i,
    input  logic       slave_md_i,
    input  logic       slave_br_i,
    output logic       conflict_o
);

    logic raw;
    logic md_clash;

    // Slave reads what the master is about to write
    assign raw = (master_dst_i != 5'd0) &&
                 ((slave_rs_i == master_dst_i) || (slave_rt_i == master_dst_i));

    // The mul/div unit accepts one op per cycle
    assign md_clash = master_md_i & slave_md_i;

    // A branch must lead the next pair so it travels with its delay slot
    assign conflict_o = raw | md_clash | slave_br_i;

endmodule

// File: rtl/issue_queue.sv
// Circular issue queue between fetch and execute. Accepts up to two entries
// per cycle and issues the head (master) and, when macro DUAL_ISSUE_EN is
// defined and no pairing conflict exists, the following entry (slave).
// Without DUAL_ISSUE_EN the slave slot is tied off and one entry pops per cycle.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stallE,
    input  logic                     push_en1,
    input  logic                     push_en2,
    input  logic [31:0]              push_pc1,
    input  logic [31:0]              push_pc2,
    input  logic [31:0]              push_instr1,
    input  logic [31:0]              push_instr2,
    input  logic [4:0]               push_dst1,
    input  logic [4:0]               push_dst2,
    input  logic                     push_md1,
    input  logic                     push_md2,
    input  logic                     push_br1,
    input  logic                     push_br2,
    output logic                     full,
    output logic                     master_valid,
    output logic                     slave_valid,
    output logic [31:0]              master_pc,
    output logic [31:0]              master_instr,
    output logic [31:0]              slave_pc,
    output logic [31:0]              slave_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    iq_entry_t         head;
    iq_entry_t         wr_e1, wr_e2;
    logic              push_ok;
    logic [1:0]        push_cnt;
    logic [1:0]        pop_cnt;
    logic              unused_head;

    assign head  = mem_q[rd_ptr_q];
    assign wr_e1 = '{pc: push_pc1, instr: push_instr1, dst: push_dst1, md: push_md1, br: push_br1};
    assign wr_e2 = '{pc: push_pc2, instr: push_instr2, dst: push_dst2, md: push_md2, br: push_br2};

    assign count        = count_q;
    assign full         = count_q > CW'(DEPTH - 2);
    assign master_valid = count_q != '0;
    assign master_pc    = master_valid ? head.pc    : 32'd0;
    assign master_instr = master_valid ? head.instr : 32'd0;

`ifdef DUAL_ISSUE_EN
    iq_entry_t         nxt;
    logic              conflict;
    logic              unused_nxt;

    assign nxt = mem_q[rd_ptr_q + PW'(1)];

    dual_issue_check u_check (
        .master_dst_i (head.dst),
        .master_md_i  (head.md),
        .slave_rs_i   (instr_rs(nxt.instr)),
        .slave_rt_i   (instr_rt(nxt.instr)),
        .slave_md_i   (nxt.md),
        .slave_br_i   (nxt.br),
        .conflict_o   (conflict)
    );

    assign slave_valid = (count_q >= CW'(2)) & ~conflict;
    assign slave_pc    = slave_valid ? nxt.pc    : 32'd0;
    assign slave_instr = slave_valid ? nxt.instr : 32'd0;
    assign unused_nxt  = ^nxt.dst;
    assign unused_head = head.br;
`else
    assign slave_valid = 1'b0;
    assign slave_pc    = 32'd0;
    assign slave_instr = 32'd0;
    assign unused_head = ^{head.dst, head.md, head.br};
`endif

    assign push_ok  = push_en1 & ~full;
    assign push_cnt = push_ok ? (push_en2 ? 2'd2 : 2'd1) : 2'd0;
    assign pop_cnt  = stallE ? 2'd0 : ({1'b0, master_valid} + {1'b0, slave_valid});

    // Next pointers and occupancy; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_cnt);
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        count_d  = count_q + CW'(push_cnt) - CW'(pop_cnt);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Queue control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until covered by count
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wr_e1;
            if (push_en2)
                mem_q[wr_ptr_q + PW'(1)] <= wr_e2;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the issue rules.
module tb_issue_queue;

    localparam int DEPTH = 8;
`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk, rst, flush, stallE;
    logic        push_en1, push_en2;
    logic [31:0] push_pc1, push_pc2, push_instr1, push_instr2;
    logic [4:0]  push_dst1, push_dst2;
    logic        push_md1, push_md2, push_br1, push_br2;
    logic        full, master_valid, slave_valid;
    logic [31:0] master_pc, master_instr, slave_pc, slave_instr;
    logic [3:0]  count;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stallE(stallE),
        .push_en1(push_en1), .push_en2(push_en2),
        .push_pc1(push_pc1), .push_pc2(push_pc2),
        .push_instr1(push_instr1), .push_instr2(push_instr2),
        .push_dst1(push_dst1), .push_dst2(push_dst2),
        .push_md1(push_md1), .push_md2(push_md2),
        .push_br1(push_br1), .push_br2(push_br2),
        .full(full), .master_valid(master_valid), .slave_valid(slave_valid),
        .master_pc(master_pc), .master_instr(master_instr),
        .slave_pc(slave_pc), .slave_instr(slave_instr), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  dst;
        logic        md;
        logic        br;
    } ent_t;

    ent_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    int          exp_count;
    logic        exp_full, exp_mv, exp_sv;
    logic [31:0] exp_mpc, exp_minstr, exp_spc, exp_sinstr;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] dst, input logic md, input logic br);
        ent_t e;
        e.pc = pc; e.instr = instr; e.dst = dst; e.md = md; e.br = br;
        return e;
    endfunction

    // Expected outputs from the queue contents and the pairing rules
    function automatic void model_eval();
        logic conf;
        conf = 1'b0;
        exp_count = q.size();
        exp_full  = (q.size() > DEPTH - 2);
        exp_mv    = (q.size() >= 1);
        if (q.size() >= 2) begin
            if (q[0].dst != 0 && (q[1].instr[25:21] == q[0].dst || q[1].instr[20:16] == q[0].dst))
                conf = 1'b1;
            if (q[0].md && q[1].md) conf = 1'b1;
            if (q[1].br) conf = 1'b1;
        end
        exp_sv     = DUAL && (q.size() >= 2) && !conf;
        exp_mpc    = exp_mv ? q[0].pc    : 32'd0;
        exp_minstr = exp_mv ? q[0].instr : 32'd0;
        exp_spc    = exp_sv ? q[1].pc    : 32'd0;
        exp_sinstr = exp_sv ? q[1].instr : 32'd0;
    endfunction

    task automatic load1(input ent_t e);
        push_pc1 = e.pc; push_instr1 = e.instr; push_dst1 = e.dst; push_md1 = e.md; push_br1 = e.br;
    endtask

    task automatic load2(input ent_t e);
        push_pc2 = e.pc; push_instr2 = e.instr; push_dst2 = e.dst; push_md2 = e.md; push_br2 = e.br;
    endtask

    task automatic drive_idle();
        flush = 1'b0; stallE = 1'b0; push_en1 = 1'b0; push_en2 = 1'b0;
    endtask

    // Advance one clock, moving the model by the same inputs
    task automatic tick();
        ent_t nq[$];
        int   n;
        model_eval();
        nq = q;
        if (flush) begin
            nq.delete();
        end else begin
            n = stallE ? 0 : (int'(exp_mv) + int'(exp_sv));
            for (int i = 0; i < n; i++) void'(nq.pop_front());
            if (push_en1 && !exp_full) begin
                nq.push_back(mk(push_pc1, push_instr1, push_dst1, push_md1, push_br1));
                if (push_en2) nq.push_back(mk(push_pc2, push_instr2, push_dst2, push_md2, push_br2));
            end
        end
        @(posedge clk);
        q = nq;
        @(negedge clk);
        model_eval();
    endtask

    task automatic push_pair(input ent_t a, input ent_t b);
        load1(a); load2(b); push_en1 = 1'b1; push_en2 = 1'b1;
        tick();
        push_en1 = 1'b0; push_en2 = 1'b0;
    endtask

    task automatic clean();
        drive_idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle();
        load1(mk(32'hdead, 32'hbeef, 5'd1, 1'b0, 1'b0)); load2(mk(32'h1, 32'h2, 5'd2, 1'b0, 1'b0));
        #1 rst = 1'b0;
        push_en1 = 1'b1; push_en2 = 1'b1;
        @(negedge clk); @(negedge clk);
        nvec++; if (count !== 4'd0 || full !== 1'b0) begin
            nerr++; $display("FAIL reset_count: count=%0d full=%b want 0/0", count, full);
        end
        nvec++; if (master_valid !== 1'b0 || slave_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_valid: mv=%b sv=%b want 0/0", master_valid, slave_valid);
        end
        nvec++; if ({master_pc, master_instr, slave_pc, slave_instr} !== 128'd0) begin
            nerr++; $display("FAIL reset_data: mpc=%h minstr=%h spc=%h sinstr=%h want 0", master_pc, master_instr, slave_pc, slave_instr);
        end
        drive_idle();
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        model_eval();
    endtask

    task automatic test_pair();
        clean(); stallE = 1'b1;
        push_pair(mk(32'h100, rtype(5'd1, 5'd2, 5'd3, 6'h21), 5'd3, 1'b0, 1'b0),
                  mk(32'h104, rtype(5'd1, 5'd2, 5'd4, 6'h21), 5'd4, 1'b0, 1'b0));
        nvec++; if (master_valid !== 1'b1 || slave_valid !== DUAL || count !== 4'd2) begin
            nerr++; $display("FAIL pair_issue: mv=%b sv=%b count=%0d want 1/%b/2", master_valid, slave_valid, count, DUAL);
        end
        tick();
        nvec++; if (count !== 4'd2 || master_pc !== 32'h100 || slave_pc !== (DUAL ? 32'h104 : 32'h0)) begin
            nerr++; $display("FAIL pair_stall_hold: count=%0d mpc=%h spc=%h", count, master_pc, slave_pc);
        end
        stallE = 1'b0; tick();
        nvec++; if (count !== (DUAL ? 4'd0 : 4'd1)) begin
            nerr++; $display("FAIL pair_pop: count=%0d want %0d", count, DUAL ? 0 : 1);
        end
    endtask

    task automatic test_raw();
        clean(); stallE = 1'b1;
        push_pair(mk(32'h200, rtype(5'd1, 5'd2, 5'd5, 6'h21), 5'd5, 1'b0, 1'b0),
                  mk(32'h204, rtype(5'd5, 5'd1, 5'd6, 6'h23), 5'd6, 1'b0, 1'b0));
        nvec++; if (slave_valid !== 1'b0 || master_valid !== 1'b1) begin
            nerr++; $display("FAIL raw_block: mv=%b sv=%b want 1/0", master_valid, slave_valid);
        end
        stallE = 1'b0; tick();
        nvec++; if (count !== 4'd1 || master_pc !== 32'h204 || master_instr !== rtype(5'd5, 5'd1, 5'd6, 6'h23)) begin
            nerr++; $display("FAIL raw_advance: count=%0d mpc=%h want 1/00000204", count, master_pc);
        end
    endtask

    task automatic test_md();
        clean(); stallE = 1'b1;
        push_pair(mk(32'h300, rtype(5'd1, 5'd2, 5'd0, 6'h18), 5'd0, 1'b1, 1'b0),
                  mk(32'h304, rtype(5'd3, 5'd4, 5'd0, 6'h1a), 5'd0, 1'b1, 1'b0));
        nvec++; if (slave_valid !== 1'b0) begin
            nerr++; $display("FAIL md_pair: sv=%b want 0", slave_valid);
        end
        clean(); stallE = 1'b1;
        push_pair(mk(32'h310, rtype(5'd1, 5'd2, 5'd0, 6'h18), 5'd0, 1'b1, 1'b0),
                  mk(32'h314, rtype(5'd8, 5'd9, 5'd7, 6'h21), 5'd7, 1'b0, 1'b0));
        nvec++; if (slave_valid !== DUAL || slave_pc !== (DUAL ? 32'h314 : 32'h0)) begin
            nerr++; $display("FAIL md_alu: sv=%b spc=%h want %b", slave_valid, slave_pc, DUAL);
        end
        clean(); stallE = 1'b1;
        push_pair(mk(32'h320, rtype(5'd1, 5'd2, 5'd9, 6'h21), 5'd9, 1'b0, 1'b0),
                  mk(32'h324, 32'h1000_0004, 5'd0, 1'b0, 1'b1));
        nvec++; if (slave_valid !== 1'b0) begin
            nerr++; $display("FAIL br_slave: sv=%b want 0", slave_valid);
        end
    endtask

    task automatic test_full();
        clean(); stallE = 1'b1;
        for (int i = 0; i < 4; i++)
            push_pair(mk(32'h400 + 8*i, rtype(5'd1, 5'd2, 5'd10, 6'h21), 5'd10, 1'b0, 1'b0),
                      mk(32'h404 + 8*i, rtype(5'd1, 5'd2, 5'd11, 6'h21), 5'd11, 1'b0, 1'b0));
        nvec++; if (count !== 4'd8 || full !== 1'b1) begin
            nerr++; $display("FAIL full_set: count=%0d full=%b want 8/1", count, full);
        end
        push_pair(mk(32'h4f0, 32'h0, 5'd0, 1'b0, 1'b0), mk(32'h4f4, 32'h0, 5'd0, 1'b0, 1'b0));
        nvec++; if (count !== 4'd8 || master_pc !== 32'h400) begin
            nerr++; $display("FAIL full_ignore: count=%0d mpc=%h want 8/00000400", count, master_pc);
        end
    endtask

    task automatic test_wrap();
        clean(); stallE = 1'b1;
        for (int i = 0; i < 3; i++)
            push_pair(mk(32'h500 + 8*i, rtype(5'd1, 5'd2, 5'd12, 6'h21), 5'd12, 1'b0, 1'b0),
                      mk(32'h504 + 8*i, rtype(5'd1, 5'd2, 5'd13, 6'h21), 5'd13, 1'b0, 1'b0));
        stallE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_pair(mk(32'h600 + 8*i, rtype(5'd1, 5'd2, 5'd14, 6'h21), 5'd14, 1'b0, 1'b0),
                      mk(32'h604 + 8*i, rtype(5'd1, 5'd2, 5'd15, 6'h21), 5'd15, 1'b0, 1'b0));
            if (i == 0) begin
                nvec++; if (count !== (DUAL ? 4'd6 : 4'd7)) begin
                    nerr++; $display("FAIL wrap_steady: count=%0d want %0d", count, DUAL ? 6 : 7);
                end
            end
            nvec++; if (count !== 4'(exp_count) || master_pc !== exp_mpc || slave_pc !== exp_spc) begin
                nerr++; $display("FAIL wrap_%0d: count=%0d mpc=%h spc=%h want %0d/%h/%h", i, count, master_pc, slave_pc, exp_count, exp_mpc, exp_spc);
            end
        end
    endtask

    task automatic test_flush();
        clean(); stallE = 1'b1;
        push_pair(mk(32'h700, 32'h0, 5'd0, 1'b0, 1'b0), mk(32'h704, 32'h0, 5'd0, 1'b0, 1'b0));
        flush = 1'b1;
        push_pair(mk(32'h708, 32'h0, 5'd0, 1'b0, 1'b0), mk(32'h70c, 32'h0, 5'd0, 1'b0, 1'b0));
        flush = 1'b0;
        nvec++; if (count !== 4'd0 || master_valid !== 1'b0) begin
            nerr++; $display("FAIL flush_push: count=%0d mv=%b want 0/0", count, master_valid);
        end
        push_pair(mk(32'h710, 32'h0, 5'd0, 1'b0, 1'b0), mk(32'h714, 32'h0, 5'd0, 1'b0, 1'b0));
        push_pair(mk(32'h718, 32'h0, 5'd0, 1'b0, 1'b0), mk(32'h71c, 32'h0, 5'd0, 1'b0, 1'b0));
        #2 rst = 1'b0;
        #1;
        nvec++; if (count !== 4'd0 || master_valid !== 1'b0 || slave_valid !== 1'b0 ||
                    {master_pc, master_instr, slave_pc, slave_instr} !== 128'd0) begin
            nerr++; $display("FAIL rst_midstall: count=%0d mv=%b sv=%b mpc=%h want all 0", count, master_valid, slave_valid, master_pc);
        end
        #1 rst = 1'b1;
        q.delete();
        drive_idle();
        tick();
        nvec++; if (count !== 4'd0 || master_valid !== 1'b0) begin
            nerr++; $display("FAIL rst_release: count=%0d mv=%b want 0/0", count, master_valid);
        end
    endtask

    task automatic test_random();
        ent_t a, b;
        clean();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                ent_t e;
                logic [4:0] rs, rt, d;
                rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
                e = mk($urandom, rtype(rs, rt, d, 6'h21), d, ($urandom % 4) == 0, ($urandom % 8) == 0);
                if (k == 0) a = e; else b = e;
            end
            load1(a); load2(b);
            push_en1 = ($urandom % 4) != 0;
            push_en2 = ($urandom % 2) == 0;
            stallE   = ($urandom % 3) == 0;
            flush    = ($urandom % 32) == 0;
            nvec++; if (count !== 4'(exp_count) || full !== exp_full) begin
                nerr++; $display("FAIL rand_count c=%0d: count=%0d full=%b want %0d/%b", c, count, full, exp_count, exp_full);
            end
            nvec++; if (master_valid !== exp_mv || slave_valid !== exp_sv) begin
                nerr++; $display("FAIL rand_valid c=%0d: mv=%b sv=%b want %b/%b", c, master_valid, slave_valid, exp_mv, exp_sv);
            end
            nvec++; if (master_pc !== exp_mpc || master_instr !== exp_minstr || slave_pc !== exp_spc || slave_instr !== exp_sinstr) begin
                nerr++; $display("FAIL rand_data c=%0d: mpc=%h minstr=%h spc=%h sinstr=%h want %h/%h/%h/%h", c, master_pc, master_instr, slave_pc, slave_instr, exp_mpc, exp_minstr, exp_spc, exp_sinstr);
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_pair();
        test_raw();
        test_md();
        test_full();
        test_wrap();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
